// File: rtl/hdlverifier_handshake_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : hdlverifier_handshake_tx_if
// Brief    : Upstream valid/ready port plus req/ack CDC handshake signals.
// Revision : 1.0 - initial release
// ============================================================================
interface hdlverifier_handshake_tx_if #(
    parameter int WIDTH = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] tx_data;
    logic             tx_req;
    logic             tx_ack;
    logic             tx_done;
    logic             err;
    logic             err_clr;

    // master is the transmitter block itself; slave is its environment
    modport master (
        input  in_valid, in_data, tx_ack, err_clr,
        output in_ready, tx_data, tx_req, tx_done, err
    );

    modport slave (
        output in_valid, in_data, tx_ack, err_clr,
        input  in_ready, tx_data, tx_req, tx_done, err
    );
endinterface
`default_nettype wire

// File: rtl/hdlverifier_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : hdlverifier_handshake_tx
// Brief    : Source side of a four-phase req/ack multi-bit clock-domain
//            crossing with acknowledge synchronizer and timeout watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module hdlverifier_handshake_tx #(
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    hdlverifier_handshake_tx_if.master bus
);

    // A zero TIMEOUT disables the watchdog; keep a 1-bit counter so widths stay legal.
    localparam int               CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_REQ     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [WIDTH-1:0]       tx_data_q;
    logic [WIDTH-1:0]       tx_data_d;
    logic                   tx_req_q;
    logic                   tx_req_d;
    logic                   tx_done_q;
    logic                   tx_done_d;
    logic                   err_q;
    logic                   err_d;
    logic                   abort_q;
    logic                   abort_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    logic                   ack_s;
    logic                   in_ready;
    logic                   accept;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   timeout_hit;
    logic                   set_err;

    // Acknowledge synchronizer: tx_ack enters at bit 0, ack_s leaves the top.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.tx_ack};
    assign ack_s  = sync_q[SYNC_STAGES-1];

    assign in_ready    = (state_q == S_IDLE) && !ack_s;
    assign accept      = bus.in_valid && in_ready;
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        abort_d   = abort_q;
        tx_done_d = 1'b0;
        set_err   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_SETUP;
                    tx_data_d = bus.in_data;
                    abort_d   = 1'b0;
                end
            end
            S_SETUP: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (ack_s) begin
                    state_d = S_RELEASE;
                end else if (timeout_hit) begin
                    state_d = S_RELEASE;
                    set_err = 1'b1;
                    abort_d = 1'b1;
                end
            end
            S_RELEASE: begin
                if (!ack_s) begin
                    state_d   = S_IDLE;
                    tx_done_d = !abort_q;
                end else if (timeout_hit) begin
                    // Receiver never dropped ack; in_ready then waits on ack_s in IDLE.
                    state_d = S_IDLE;
                    set_err = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cnt_d = '0;
        if ((state_d == state_q) && ((state_q == S_REQ) || (state_q == S_RELEASE))) begin
            cnt_d = cnt_inc;
        end

        tx_req_d = (state_d == S_REQ);

        // A timeout in the same cycle as err_clr keeps the flag set.
        err_d = err_q;
        if (set_err) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_q <= '0;
            tx_req_q  <= 1'b0;
            tx_done_q <= 1'b0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
            cnt_q     <= '0;
            sync_q    <= '0;
        end else begin
            tx_data_q <= tx_data_d;
            tx_req_q  <= tx_req_d;
            tx_done_q <= tx_done_d;
            err_q     <= err_d;
            abort_q   <= abort_d;
            cnt_q     <= cnt_d;
            sync_q    <= sync_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_req   = tx_req_q;
    assign bus.tx_done  = tx_done_q;
    assign bus.err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_hdlverifier_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdlverifier_handshake_tx
// Brief    : Directed self-checking bench for hdlverifier_handshake_tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdlverifier_handshake_tx;

    localparam int WIDTH       = 10;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hdlverifier_handshake_tx_if #(.WIDTH(WIDTH)) bus ();

    hdlverifier_handshake_tx #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ack source: 0 = manual, 1 = direct loop from tx_req, 2 = loop through one flop
    int   mode    = 0;
    logic man_ack = 1'b0;
    logic lb_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lb_q <= 1'b0;
        else        lb_q <= bus.tx_req;
    end

    assign bus.tx_ack = (mode == 2) ? lb_q : (mode == 1) ? bus.tx_req : man_ack;

    int               n_checks = 0;
    int               n_err    = 0;
    int               edge_n   = 0;
    int               done_cnt = 0;
    int               stab_bad = 0;
    int               acc_edge[$];
    logic [WIDTH-1:0] req_data[$];
    logic             prev_req = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    always @(posedge clk) edge_n++;

    // Mid-cycle monitor: accepts land on the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) acc_edge.push_back(edge_n + 1);
            if (bus.tx_req && !prev_req) req_data.push_back(bus.tx_data);
            if (bus.tx_req && prev_req && (bus.tx_data !== prev_data)) stab_bad++;
            if (bus.tx_done === 1'b1) done_cnt++;
            prev_req  = bus.tx_req;
            prev_data = bus.tx_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a word with in_valid high and return the edge number of its accept.
    task automatic send(input logic [WIDTH-1:0] d, input string tag, output int e);
        int n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        #1;
        while ((bus.in_ready !== 1'b1) && (n < 100)) begin
            step();
            n++;
        end
        check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
        step();
        e = edge_n;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while ((done_cnt < target) && (n < 60)) begin
            step();
            n++;
        end
    endtask

    initial begin
        int               e0, e1, e2, hi, base_d, base_r;
        logic [WIDTH-1:0] words [3];
        words[0] = 10'h001;
        words[1] = 10'h3FF;
        words[2] = 10'h155;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.err_clr  = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_tx_req",  {31'd0, bus.tx_req},  32'd0);
        check("rst_tx_data", {22'd0, bus.tx_data}, 32'd0);
        check("rst_tx_done", {31'd0, bus.tx_done}, 32'd0);
        check("rst_err",     {31'd0, bus.err},     32'd0);

        // Release with a word waiting, acked through one delay flop
        rst_n        = 1'b1;
        mode         = 2;
        bus.in_valid = 1'b1;
        bus.in_data  = 10'h2A5;
        #1;
        check("rel_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        check("lb_data_a",  {22'd0, bus.tx_data},  32'h2A5);
        check("lb_req_a",   {31'd0, bus.tx_req},   32'd0);
        check("lb_ready_a", {31'd0, bus.in_ready}, 32'd0);
        bus.in_data = 10'h0C3;
        step();
        check("lb_req_a1",  {31'd0, bus.tx_req},  32'd1);
        check("lb_data_a1", {22'd0, bus.tx_data}, 32'h2A5);
        repeat (3) step();
        check("lb_req_a4", {31'd0, bus.tx_req}, 32'd1);
        step();
        check("lb_req_a5", {31'd0, bus.tx_req}, 32'd0);
        repeat (3) step();
        check("lb_done_a8",  {31'd0, bus.tx_done},  32'd0);
        check("lb_ready_a8", {31'd0, bus.in_ready}, 32'd0);
        step();
        check("lb_done_a9",  {31'd0, bus.tx_done},  32'd1);
        check("lb_ready_a9", {31'd0, bus.in_ready}, 32'd1);
        check("lb_data_a9",  {22'd0, bus.tx_data},  32'h2A5);
        step();
        check("lb_done_a10", {31'd0, bus.tx_done}, 32'd0);
        check("lb_data_a10", {22'd0, bus.tx_data}, 32'h0C3);
        bus.in_valid = 1'b0;
        check("lb_acc_count",   acc_edge.size(), 32'd2);
        check("lb_acc_spacing", acc_edge[1] - acc_edge[0], 32'd10);
        wait_done(2);
        check("lb_done_count", done_cnt, 32'd2);

        // Back-to-back stream on the direct loop
        mode   = 1;
        base_d = done_cnt;
        base_r = req_data.size();
        send(words[0], "bb0", e0);
        send(words[1], "bb1", e1);
        send(words[2], "bb2", e2);
        bus.in_valid = 1'b0;
        check("bb_space01", e1 - e0, 32'd8);
        check("bb_space12", e2 - e1, 32'd8);
        wait_done(base_d + 3);
        check("bb_done_count", done_cnt - base_d, 32'd3);
        check("bb_req_count", req_data.size() - base_r, 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bb_order%0d", i), {22'd0, req_data[base_r + i]}, {22'd0, words[i]});
        end
        check("bb_stable", stab_bad, 32'd0);

        // Receiver silent: REQ times out
        mode    = 0;
        man_ack = 1'b0;
        base_d  = done_cnt;
        hi      = 0;
        send(10'h333, "to", e0);
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (bus.tx_req === 1'b1) hi++;
            if (k == 8) check("to_err_k8", {31'd0, bus.err}, 32'd0);
            if (k == 9) begin
                check("to_err_k9", {31'd0, bus.err},    32'd1);
                check("to_req_k9", {31'd0, bus.tx_req}, 32'd0);
            end
        end
        check("to_req_cycles", hi, 32'd8);
        check("to_no_done", done_cnt - base_d, 32'd0);
        check("to_ready", {31'd0, bus.in_ready}, 32'd1);
        check("to_err_sticky", {31'd0, bus.err}, 32'd1);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check("to_err_clr", {31'd0, bus.err}, 32'd0);

        // Ack rises and never falls: RELEASE times out
        base_d = done_cnt;
        send(10'h0AA, "st", e0);
        bus.in_valid = 1'b0;
        step();
        man_ack = 1'b1;
        for (int k = 2; k <= 12; k++) begin
            step();
            if (k == 3)  check("st_req_k3", {31'd0, bus.tx_req}, 32'd1);
            if (k == 4)  check("st_req_k4", {31'd0, bus.tx_req}, 32'd0);
            if (k == 11) check("st_err_k11", {31'd0, bus.err}, 32'd0);
            if (k == 12) begin
                check("st_err_k12",   {31'd0, bus.err},      32'd1);
                check("st_ready_k12", {31'd0, bus.in_ready}, 32'd0);
            end
        end
        repeat (4) step();
        check("st_ready_held", {31'd0, bus.in_ready}, 32'd0);
        man_ack = 1'b0;
        step();
        check("st_ready_e1", {31'd0, bus.in_ready}, 32'd0);
        step();
        check("st_ready_e2", {31'd0, bus.in_ready}, 32'd1);
        check("st_no_done", done_cnt - base_d, 32'd0);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check("st_err_clr", {31'd0, bus.err}, 32'd0);

        // Reset while in REQ, then a fresh transfer
        send(10'h111, "mr", e0);
        bus.in_valid = 1'b0;
        repeat (2) step();
        check("mr_req_before", {31'd0, bus.tx_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_req_async",  {31'd0, bus.tx_req},  32'd0);
        check("mr_data_async", {22'd0, bus.tx_data}, 32'd0);
        repeat (2) step();
        rst_n  = 1'b1;
        mode   = 1;
        base_d = done_cnt;
        send(10'h0F0, "mr", e0);
        bus.in_valid = 1'b0;
        wait_done(base_d + 1);
        check("mr_done", done_cnt - base_d, 32'd1);
        check("mr_req_data", {22'd0, req_data[req_data.size() - 1]}, 32'h0F0);
        check("mr_tx_data", {22'd0, bus.tx_data}, 32'h0F0);
        check("mr_err", {31'd0, bus.err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
